// File: rtl/fp_wb_pkg.sv
// Shared types for the FP register-file writeback arbiter.
package fp_wb_pkg;

   localparam int FP_NREGS = 32;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } fp_wb_entry_t;

   typedef enum logic {
      SRC_FPU = 1'b0,
      SRC_LSU = 1'b1
   } fp_wb_src_e;

   function automatic logic [FP_NREGS-1:0] rd_onehot(input logic [4:0] rd);
      rd_onehot     = '0;
      rd_onehot[rd] = 1'b1;
   endfunction

endpackage

// File: rtl/fp_wb_arbiter_if.sv
// Producer channels, register-file write port and pending mask of the FP writeback arbiter.
interface fp_wb_arbiter_if;
   import fp_wb_pkg::*;

   // A transfer happens on a rising edge where valid && ready; ready depends
   // only on queue occupancy, never on valid, and producers may drop valid freely.
   logic                fpu_valid;
   logic                fpu_ready;
   logic [4:0]          fpu_rd;
   logic [31:0]         fpu_data;
   logic                lsu_valid;
   logic                lsu_ready;
   logic [4:0]          lsu_rd;
   logic [31:0]         lsu_data;
   logic                wr_en;
   logic [4:0]          wr_addr;
   logic [31:0]         wr_data;
   logic [FP_NREGS-1:0] pend_mask;
   fp_wb_src_e          last_grant;

   modport slave (
      input  fpu_valid, fpu_rd, fpu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      output fpu_ready, lsu_ready,
      output wr_en, wr_addr, wr_data, pend_mask, last_grant
   );

   modport master (
      output fpu_valid, fpu_rd, fpu_data,
      output lsu_valid, lsu_rd, lsu_data,
      input  fpu_ready, lsu_ready,
      input  wr_en, wr_addr, wr_data, pend_mask, last_grant
   );

endinterface

// File: rtl/fp_wb_fifo.sv
// Per-source result queue; exposes per-slot valid/rd so the top can build the pending mask.
module fp_wb_fifo
   import fp_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  fp_wb_entry_t          push_entry,
   input  logic                  pop,
   output fp_wb_entry_t          head,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH-1:0]      ent_valid,
   output logic [DEPTH-1:0][4:0] ent_rd
);

   localparam int PW = $clog2(DEPTH);

   fp_wb_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          do_push;
   logic          do_pop;

   // Full is judged on the pre-edge occupancy, so a pop on the same edge does not free a slot.
   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic [PW-1:0] off;
      assign off          = PW'(i) - rd_ptr;
      assign ent_valid[i] = ({1'b0, off} < count);
      assign ent_rd[i]    = mem[i].rd;
   end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Round-robin writeback arbiter: two result queues onto one FP register-file write port.
module fp_wb_arbiter
   import fp_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input logic             clk,
   input logic             rst_n,
   fp_wb_arbiter_if.slave  bus
);

   fp_wb_entry_t          fpu_in;
   fp_wb_entry_t          lsu_in;
   fp_wb_entry_t          fpu_head;
   fp_wb_entry_t          lsu_head;
   logic                  fpu_full;
   logic                  fpu_empty;
   logic                  lsu_full;
   logic                  lsu_empty;
   logic [DEPTH-1:0]      fpu_ev;
   logic [DEPTH-1:0]      lsu_ev;
   logic [DEPTH-1:0][4:0] fpu_er;
   logic [DEPTH-1:0][4:0] lsu_er;
   logic                  gnt_fpu;
   logic                  gnt_lsu;
   logic                  contend;
   fp_wb_src_e            last_grant;
   logic                  wr_en_q;
   logic [4:0]            wr_addr_q;
   logic [31:0]           wr_data_q;
   logic [FP_NREGS-1:0]   pend;

   assign fpu_in = '{rd: bus.fpu_rd, data: bus.fpu_data};
   assign lsu_in = '{rd: bus.lsu_rd, data: bus.lsu_data};

   fp_wb_fifo #(.DEPTH(DEPTH)) u_fpu_q (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (bus.fpu_valid),
      .push_entry (fpu_in),
      .pop        (gnt_fpu),
      .head       (fpu_head),
      .full       (fpu_full),
      .empty      (fpu_empty),
      .ent_valid  (fpu_ev),
      .ent_rd     (fpu_er)
   );

   fp_wb_fifo #(.DEPTH(DEPTH)) u_lsu_q (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (bus.lsu_valid),
      .push_entry (lsu_in),
      .pop        (gnt_lsu),
      .head       (lsu_head),
      .full       (lsu_full),
      .empty      (lsu_empty),
      .ent_valid  (lsu_ev),
      .ent_rd     (lsu_er)
   );

   assign bus.fpu_ready = !fpu_full;
   assign bus.lsu_ready = !lsu_full;

   // last_grant only moves on contention, so an uncontested grant does not steal a turn.
   assign contend = !fpu_empty && !lsu_empty;
   assign gnt_fpu = !fpu_empty && (lsu_empty || last_grant == SRC_LSU);
   assign gnt_lsu = !lsu_empty && !gnt_fpu;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         last_grant <= SRC_LSU;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         if (contend) last_grant <= gnt_fpu ? SRC_FPU : SRC_LSU;
         wr_en_q <= gnt_fpu || gnt_lsu;
         if (gnt_fpu) begin
            wr_addr_q <= fpu_head.rd;
            wr_data_q <= fpu_head.data;
         end else if (gnt_lsu) begin
            wr_addr_q <= lsu_head.rd;
            wr_data_q <= lsu_head.data;
         end
      end
   end

   always_comb begin
      pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fpu_ev[i]) pend = pend | rd_onehot(fpu_er[i]);
         if (lsu_ev[i]) pend = pend | rd_onehot(lsu_er[i]);
      end
      if (wr_en_q) pend = pend | rd_onehot(wr_addr_q);
   end

   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.pend_mask  = pend;
   assign bus.last_grant = last_grant;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Scoreboard bench for fp_wb_arbiter: directed scenarios plus a random soak.
`timescale 1ns/1ps
module tb_fp_wb_arbiter;
   import fp_wb_pkg::*;

   localparam int DEPTH = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fp_wb_arbiter_if bus ();

   fp_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [36:0] exp_fpu_q [$];
   logic [36:0] exp_lsu_q [$];
   logic [36:0] wr_log    [$];
   int          n_checks   = 0;
   int          n_pass     = 0;
   int          lsu_stalls = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: expected mask is every accepted-but-not-yet-retired rd.
   always @(negedge clk) begin
      logic [31:0] em;
      logic [36:0] entry;
      logic [36:0] exp_e;
      if (!rst_n) begin
         em = '0;
         foreach (exp_fpu_q[i]) em[exp_fpu_q[i][36:32]] = 1'b1;
         foreach (exp_lsu_q[i]) em[exp_lsu_q[i][36:32]] = 1'b1;
         check("pend_mask", 64'(bus.pend_mask), 64'(em));
         if (bus.wr_en) begin
            entry = {bus.wr_addr, bus.wr_data};
            wr_log.push_back(entry);
            if (exp_fpu_q.size() > 0 && exp_fpu_q[0] == entry) begin
               exp_e = exp_fpu_q.pop_front();
            end else if (exp_lsu_q.size() > 0 && exp_lsu_q[0] == entry) begin
               exp_e = exp_lsu_q.pop_front();
            end else if (exp_fpu_q.size() > 0) begin
               exp_e = exp_fpu_q[0];
            end else if (exp_lsu_q.size() > 0) begin
               exp_e = exp_lsu_q[0];
            end else begin
               exp_e = ~entry;
            end
            check("wr_entry", 64'(entry), 64'(exp_e));
         end
         check("fpu_ready", 64'(bus.fpu_ready), 64'(exp_fpu_q.size() < DEPTH));
         check("lsu_ready", 64'(bus.lsu_ready), 64'(exp_lsu_q.size() < DEPTH));
      end
   end

   // Drivers run at negedge+1 and return at the following negedge+1.
   task automatic send_fpu(input logic [4:0] rd, input logic [31:0] data);
      int guard = 0;
      bus.fpu_valid = 1'b1;
      bus.fpu_rd    = rd;
      bus.fpu_data  = data;
      while (!bus.fpu_ready && guard < 50) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         n_checks++;
         $display("FAIL fpu_accept_timeout: got ready=0 expected ready=1 within 50 cycles");
      end else begin
         exp_fpu_q.push_back({rd, data});
      end
      @(negedge clk); #1;
      bus.fpu_valid = 1'b0;
   endtask

   task automatic send_lsu(input logic [4:0] rd, input logic [31:0] data);
      int guard = 0;
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = rd;
      bus.lsu_data  = data;
      while (!bus.lsu_ready && guard < 50) begin
         @(negedge clk); #1;
         guard++;
         lsu_stalls++;
      end
      if (guard >= 50) begin
         n_checks++;
         $display("FAIL lsu_accept_timeout: got ready=0 expected ready=1 within 50 cycles");
      end else begin
         exp_lsu_q.push_back({rd, data});
      end
      @(negedge clk); #1;
      bus.lsu_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((exp_fpu_q.size() != 0 || exp_lsu_q.size() != 0) && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d/%0d entries outstanding expected 0/0",
                  exp_fpu_q.size(), exp_lsu_q.size());
      end
      @(negedge clk); #1;
   endtask

   initial begin
      bus.fpu_valid = 1'b0;
      bus.fpu_rd    = '0;
      bus.fpu_data  = '0;
      bus.lsu_valid = 1'b0;
      bus.lsu_rd    = '0;
      bus.lsu_data  = '0;

      // Reset values.
      #2 rst_n = 1'b1;
      @(negedge clk); #1;
      check("rst_wr_en",      64'(bus.wr_en),      64'd0);
      check("rst_wr_addr",    64'(bus.wr_addr),    64'd0);
      check("rst_wr_data",    64'(bus.wr_data),    64'd0);
      check("rst_pend_mask",  64'(bus.pend_mask),  64'd0);
      check("rst_fpu_ready",  64'(bus.fpu_ready),  64'd1);
      check("rst_lsu_ready",  64'(bus.lsu_ready),  64'd1);
      check("rst_last_grant", 64'(bus.last_grant), 64'(SRC_LSU));
      @(negedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk); #1;

      // Single FPU write: two-cycle latency, mask bit 3 for two cycles.
      send_fpu(5'd3, 32'h3F80_0000);
      check("single_c1_wr_en", 64'(bus.wr_en),     64'd0);
      check("single_c1_mask",  64'(bus.pend_mask), 64'h8);
      @(negedge clk); #1;
      check("single_c2_wr_en", 64'(bus.wr_en),     64'd1);
      check("single_c2_addr",  64'(bus.wr_addr),   64'd3);
      check("single_c2_data",  64'(bus.wr_data),   64'h3F80_0000);
      check("single_c2_mask",  64'(bus.pend_mask), 64'h8);
      @(negedge clk); #1;
      check("single_c3_wr_en", 64'(bus.wr_en),     64'd0);
      check("single_c3_mask",  64'(bus.pend_mask), 64'h0);
      wait_idle();

      // First contention goes to FPU, the repeat goes to LSU.
      wr_log.delete();
      fork
         send_fpu(5'd1, 32'h0000_0111);
         send_lsu(5'd2, 32'h0000_0222);
      join
      wait_idle();
      check("cont1_len",   64'(wr_log.size()),    64'd2);
      check("cont1_first", 64'(wr_log[0][36:32]), 64'd1);
      check("cont1_second",64'(wr_log[1][36:32]), 64'd2);
      wr_log.delete();
      fork
         send_fpu(5'd6, 32'h0000_0666);
         send_lsu(5'd7, 32'h0000_0777);
      join
      wait_idle();
      check("cont2_len",   64'(wr_log.size()),    64'd2);
      check("cont2_first", 64'(wr_log[0][36:32]), 64'd7);
      check("cont2_second",64'(wr_log[1][36:32]), 64'd6);

      // Duplicate rd: both writes happen, bit 5 clears only after the second.
      wr_log.delete();
      send_fpu(5'd5, 32'h0000_000A);
      send_fpu(5'd5, 32'h0000_000B);
      check("dup_w1_data", 64'(bus.wr_data),      64'hA);
      check("dup_w1_bit5", 64'(bus.pend_mask[5]), 64'd1);
      @(negedge clk); #1;
      check("dup_w2_data", 64'(bus.wr_data),      64'hB);
      check("dup_w2_bit5", 64'(bus.pend_mask[5]), 64'd1);
      @(negedge clk); #1;
      check("dup_after_wr_en", 64'(bus.wr_en),        64'd0);
      check("dup_after_bit5",  64'(bus.pend_mask[5]), 64'd0);
      wait_idle();
      check("dup_len", 64'(wr_log.size()), 64'd2);

      // Backpressure: LSU queue fills while FPU takes alternate grants.
      wr_log.delete();
      lsu_stalls = 0;
      fork
         begin
            send_fpu(5'd10, 32'hF000_0010);
            send_fpu(5'd11, 32'hF000_0011);
            send_fpu(5'd12, 32'hF000_0012);
         end
         begin
            send_lsu(5'd20, 32'h1000_0020);
            send_lsu(5'd21, 32'h1000_0021);
            send_lsu(5'd22, 32'h1000_0022);
         end
      join
      wait_idle();
      check("bp_lsu_stalls", 64'(lsu_stalls),       64'd1);
      check("bp_len",        64'(wr_log.size()),    64'd6);
      check("bp_order0",     64'(wr_log[0][36:32]), 64'd10);
      check("bp_order1",     64'(wr_log[1][36:32]), 64'd20);
      check("bp_order2",     64'(wr_log[2][36:32]), 64'd11);
      check("bp_order3",     64'(wr_log[3][36:32]), 64'd21);
      check("bp_order4",     64'(wr_log[4][36:32]), 64'd12);
      check("bp_order5",     64'(wr_log[5][36:32]), 64'd22);

      // Reset with two entries queued: outputs clear without a clock edge.
      fork
         send_fpu(5'd8, 32'h0000_0088);
         send_lsu(5'd9, 32'h0000_0099);
      join
      rst_n = 1'b1;
      #1;
      check("mid_rst_wr_en",     64'(bus.wr_en),     64'd0);
      check("mid_rst_pend_mask", 64'(bus.pend_mask), 64'd0);
      check("mid_rst_fpu_ready", 64'(bus.fpu_ready), 64'd1);
      check("mid_rst_lsu_ready", 64'(bus.lsu_ready), 64'd1);
      exp_fpu_q.delete();
      exp_lsu_q.delete();
      wr_log.delete();
      @(negedge clk);
      @(negedge clk); #1;
      rst_n = 1'b0;
      repeat (4) begin
         @(negedge clk); #1;
      end
      check("post_rst_no_writes", 64'(wr_log.size()), 64'd0);

      // Random soak on both sources.
      fork
         for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 99) < 60) begin
               bus.fpu_valid = 1'b1;
               bus.fpu_rd    = 5'($urandom_range(0, 7));
               bus.fpu_data  = $urandom;
               if (bus.fpu_ready) exp_fpu_q.push_back({bus.fpu_rd, bus.fpu_data});
            end else begin
               bus.fpu_valid = 1'b0;
            end
            @(negedge clk); #1;
         end
         for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 99) < 60) begin
               bus.lsu_valid = 1'b1;
               bus.lsu_rd    = 5'($urandom_range(4, 11));
               bus.lsu_data  = $urandom;
               if (bus.lsu_ready) exp_lsu_q.push_back({bus.lsu_rd, bus.lsu_data});
            end else begin
               bus.lsu_valid = 1'b0;
            end
            @(negedge clk); #1;
         end
      join
      bus.fpu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      wait_idle();
      check("final_pend_mask", 64'(bus.pend_mask), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fp_wb_arbiter.md
# fp_wb_arbiter

Writeback arbiter for the floating-point register file write port. It takes results from two independent producers, the FPU result channel and the FP load channel. Each producer has a valid/ready handshake and its own per-source queue. The arbiter serialises the queued results round-robin onto the single write port (write enable, register address, write data). It also exports a pending-write mask, which issue logic uses for RAW/WAW stalls on f0-f31.

## Interface

Parameters:
- DEPTH, 2: entries per source queue; power of two, ≥2.

Ports (reset rst_n, asynchronous, active-high; clock clk):
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous reset, active-high.
- fpu_valid  in  1  FPU result offered.
- fpu_ready  out  1  FPU queue can accept.
- fpu_rd  in  5  FPU destination register.
- fpu_data  in  32  FPU result.
- lsu_valid  in  1  FP load result offered.
- lsu_ready  out  1  load queue can accept.
- lsu_rd  in  5  load destination register.
- lsu_data  in  32  load data.
- wr_en  out  1  register file write enable.
- wr_addr  out  5  register file write address.
- wr_data  out  32  register file write data.
- pend_mask  out  32  bit r set while a write to fr is queued or being driven.

## Operation

- Accept: a transfer occurs on an edge where valid && ready; the {rd, data} entry is pushed into that source's queue.
- Ready: ready = !full of that queue, based on the occupancy before the edge. No same-cycle accept into a full queue, even if that queue pops on the same edge.
- Order within a source: FIFO order is preserved.
- Order across sources: not guaranteed. Issue logic must stall on pend_mask for any register that both sources could target.
- Grant: each cycle, if at least one queue is non-empty, one head is popped into the output register.
  - Only one queue non-empty: that queue is granted.
  - Both non-empty: grant the source not granted last time, then update last_grant.
  - last_grant resets to LSU, so FPU wins the first contention.
- Output register: wr_en/wr_addr/wr_data load the popped entry. With no pop, wr_en loads 0 and wr_addr/wr_data hold their previous values.
- pend_mask: OR of the one-hot(rd) of every valid entry in both queues, plus one-hot(wr_addr) when wr_en=1. It is combinational from state only, with no path from the *_valid inputs.
- Simultaneous push and pop on the same queue: allowed when the queue is not full; occupancy is unchanged.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. A count of log2(DEPTH)+1 bits distinguishes full from empty.
- Duplicate rd: two queued writes to the same register are both performed, in grant order; pend_mask stays set until the last one leaves wr_en.

## Timing

- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0.
  - Queues empty, so pend_mask=0.
  - fpu_ready=1, lsu_ready=1.
  - last_grant=LSU.
- Producers must hold valid low while rst_n=1.
- Reset mid-operation: all queued entries are discarded, and the outputs take their reset values immediately (asynchronously).
- Latency: an entry accepted at edge E into an empty, uncontested queue drives wr_en=1 in the cycle after edge E+1, i.e. 2 cycles. The register file captures it at edge E+2.
- Throughput: one write per cycle total. With both sources saturated, each source is granted every other cycle.
- pend_mask timing: the bit rises in the cycle after the accepting edge. It falls in the cycle after the last wr_en cycle for that register.

## Structure

- Package fp_wb_pkg:
  - typedef fp_wb_entry_t {logic [4:0] rd; logic [31:0] data;}.
  - enum fp_wb_src_e {SRC_FPU, SRC_LSU}.
  - localparam FP_NREGS = 32.
- Sub-module fp_wb_fifo: parameterised by DEPTH, entry type fp_wb_entry_t.
  - Ports: push/pop, head, full/empty, per-entry valid-and-rd vector for mask generation.
  - Instantiated twice, once per source.
- Top level holds the round-robin pointer, the output register and the pend_mask reduction.

## Test plan

- Single FPU write: fpu rd=3, data=0x3F800000 at edge 0 -> wr_en=1, wr_addr=3, wr_data=0x3F800000 in the cycle after edge 1; pend_mask=0x8 for two cycles, then 0.
- Contention: both sources push at the same edge (FPU rd=1, LSU rd=2) -> rd=1 written first, rd=2 next cycle; a repeat contention grants LSU first.
- Full/backpressure, DEPTH=2: three LSU pushes on back-to-back cycles while FPU traffic holds priority -> lsu_ready=0 after two entries; no entry is lost; writes occur in order.
- Duplicate rd: FPU writes rd=5 with 0xA, then rd=5 with 0xB -> two writes, last value 0xB; bit 5 of pend_mask is cleared only after the second write.
- Reset mid-operation: assert rst_n with 2 entries queued -> wr_en=0 and pend_mask=0 immediately; after release both ready=1 and no stale writes occur.
- Sustained random traffic on both sources (1000 cycles) against a scoreboard model -> every accepted entry is written exactly once; per-source order is preserved; pend_mask matches the model every cycle.
